mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
Consumer end of the 3-bit LFSR random stream: pulls random values over a valid/ready handshake and maps them non-uniformly onto one of four boxes. Shows the "mole" in that box for a timed window and judges player hit inputs. Tracks score and misses, and ends the round after MAX_MISSES misses. Sits between the LFSR source and the display/score logic of the game top level.

Parameters:
SHOW_CYCLES, 25000000, cycles a mole stays up (minimum 4)
GAP_CYCLES, 12500000, blank cycles between moles (minimum 1)
SCORE_W, 8, score counter width
MAX_MISSES, 3, misses that end the round (1..15)

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
resetn  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; starts or restarts a round
rnd_valid  input  1  random value available
rnd_value  input  3  random value from LFSR
rnd_ready  output  1  controller accepts rnd_value this cycle
hit  input  4  per-box press pulses, already synchronised and debounced
mole  output  4  one-hot active box; 0 when no mole is up
score  output  SCORE_W  hits this round, saturating
misses  output  4  misses this round
hit_flag  output  1  one-cycle pulse on a scored hit
miss_flag  output  1  one-cycle pulse on a timeout miss
game_over  output  1  high from round end until next start

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, mole=0, score=0, misses=0, rnd_ready=0, hit_flag=0, miss_flag=0, game_over=0. The timer is cleared.
- Box map for rnd_value:
  - 001, 010, 100 -> box0 (mole=0001)
  - 011, 101 -> box1 (0010)
  - 110 -> box2 (0100)
  - 111 -> box3 (1000)
  - 000 -> invalid
- IDLE: outputs idle.
  - start=1 -> clear score/misses/game_over, go to DRAW.
- DRAW: rnd_ready=1 (registered output, high for the whole state).
  - rnd_valid&rnd_ready with a valid code -> latch box, go to SHOW. mole asserts the next cycle (one-cycle latency from handshake). Timer=0.
  - rnd_value=000 -> value is consumed, stay in DRAW.
  - No handshake -> wait indefinitely.
- SHOW: mole held; timer increments each cycle.
  - hit[box]=1 -> score+1 (saturate at 2^SCORE_W-1), hit_flag pulse, mole=0, go to GAP.
  - Presses on other boxes are ignored, even when simultaneous with a correct press (correct press counts).
  - Timer reaches SHOW_CYCLES-1 with no correct hit -> misses+1, miss_flag pulse, mole=0.
    - If new misses == MAX_MISSES -> game_over=1, go to OVER; else go to GAP.
  - Correct hit on the timeout cycle -> counts as a hit, not a miss.
- GAP: mole=0, rnd_ready=0. After GAP_CYCLES cycles, go to DRAW.
- OVER: game_over=1, score/misses frozen, mole=0.
  - start -> same as start in IDLE.
- start in DRAW/SHOW/GAP is ignored.
- Flags are registered and high for exactly one cycle.
- rnd_ready is never high outside DRAW.
- Reset asserted mid-round aborts immediately to the reset values.

Optional Feature:
- MOLE_SPEEDUP_EN defined:
  - A show_limit register loads SHOW_CYCLES at start.
  - Each scored hit reduces it by SHOW_CYCLES/8, floored at SHOW_CYCLES/4.
  - The SHOW timeout uses show_limit.
- Undefined: the timeout is always SHOW_CYCLES and no register exists.

Decomposition:
- Package mole_pkg holds:
  - state enum (IDLE, DRAW, SHOW, GAP, OVER)
  - default timing constants
  - BOX_NONE=4'b0000
- Sub-module mole_box_map: combinational 3-bit code -> 4-bit one-hot plus valid bit. Instantiated once; reused by the verification model.

Test Plan:
(Bench parameters: SHOW_CYCLES=8, GAP_CYCLES=4, MAX_MISSES=3.)
- Reset then start; rnd_value=110 with valid -> rnd_ready high in DRAW; mole=0100 one cycle after the handshake.
- rnd_value=000 then 011 -> 000 consumed with no mole; mole=0010 after the 011 handshake.
- Mole 0001, hit=0001 on the 3rd SHOW cycle -> score=1, hit_flag for one cycle, mole=0; DRAW re-entered after 4 GAP cycles.
- Mole 1000, hit=0001 only, no correct press -> miss at cycle 8, misses=1, miss_flag pulse, score unchanged.
- Three consecutive timeouts -> misses=3, game_over=1, rnd_ready stays 0. Then start -> score=0, misses=0, game_over=0, DRAW.
- Correct hit on the timeout cycle -> hit counted, no miss. resetn low mid-SHOW -> all outputs 0 immediately.

Source files
------------

// File: rtl/mole_round_ctrl_pkg.sv
// Shared types and default timing for the whack-a-mole round controller.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRAW = 3'd1,
    SHOW = 3'd2,
    GAP  = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam int DEF_SHOW_CYCLES = 25000000;
  localparam int DEF_GAP_CYCLES  = 12500000;
  localparam int DEF_SCORE_W     = 8;
  localparam int DEF_MAX_MISSES  = 3;

  localparam logic [3:0] BOX_NONE = 4'b0000;

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Valid/ready stream carrying 3-bit random codes from the LFSR to the round controller.
interface mole_round_ctrl_if;
  logic       rnd_valid;
  logic [2:0] rnd_value;
  logic       rnd_ready;

  modport master (output rnd_valid, output rnd_value, input rnd_ready);
  modport slave  (input rnd_valid, input rnd_value, output rnd_ready);
endinterface

// File: rtl/mole_box_map.sv
// Non-uniform map from a 3-bit random code to a one-hot box; code 000 is invalid.
module mole_box_map
  import mole_pkg::*;
(
  input  logic [2:0] code,
  output logic [3:0] box,
  output logic       valid
);

  always_comb begin
    box   = BOX_NONE;
    valid = 1'b1;
    case (code)
      3'b001, 3'b010, 3'b100: box = 4'b0001;
      3'b011, 3'b101:         box = 4'b0010;
      3'b110:                 box = 4'b0100;
      3'b111:                 box = 4'b1000;
      default:                valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: draws boxes from the random stream, times moles, scores hits.
// Optional macro MOLE_SPEEDUP_EN shortens the show window after every scored hit.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int SHOW_CYCLES = DEF_SHOW_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int MAX_MISSES  = DEF_MAX_MISSES
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  mole_round_ctrl_if.slave   rnd,
  input  logic [3:0]         hit,
  output logic [3:0]         mole,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               hit_flag,
  output logic               miss_flag,
  output logic               game_over
);

  // One timer serves both the show window and the gap; it must also hold SHOW_CYCLES itself.
  localparam int TMAX    = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);

  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           mole_d;
  logic [SCORE_W-1:0]   score_d;
  logic [3:0]           misses_d;
  logic                 ready_q, ready_d;
  logic                 hit_flag_d, miss_flag_d, game_over_d;
  logic [TIMER_W-1:0]   show_last;

  logic [3:0]           map_box;
  logic                 map_valid;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  mole_box_map u_box_map (
    .code  (rnd.rnd_value),
    .box   (map_box),
    .valid (map_valid)
  );

  assign rnd.rnd_ready = ready_q;

`ifdef MOLE_SPEEDUP_EN
  localparam logic [TIMER_W-1:0] LIMIT_INIT  = TIMER_W'(SHOW_CYCLES);
  localparam logic [TIMER_W-1:0] LIMIT_STEP  = TIMER_W'(SHOW_CYCLES / 8);
  localparam logic [TIMER_W-1:0] LIMIT_FLOOR = TIMER_W'(SHOW_CYCLES / 4);

  logic [TIMER_W-1:0] show_limit_q, show_limit_d;

  function automatic logic [TIMER_W-1:0] next_limit(input logic [TIMER_W-1:0] lim);
    return (lim >= LIMIT_FLOOR + LIMIT_STEP) ? lim - LIMIT_STEP : LIMIT_FLOOR;
  endfunction

  assign show_last = show_limit_q - 1'b1;

  always_comb begin
    show_limit_d = show_limit_q;
    if ((state_q == IDLE || state_q == OVER) && start)
      show_limit_d = LIMIT_INIT;
    else if (state_q == SHOW && (|(hit & mole)))
      show_limit_d = next_limit(show_limit_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) show_limit_q <= LIMIT_INIT;
    else         show_limit_q <= show_limit_d;
  end
`else
  assign show_last = TIMER_W'(SHOW_CYCLES - 1);
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mole_d      = mole;
    score_d     = score;
    misses_d    = misses;
    ready_d     = 1'b0;
    hit_flag_d  = 1'b0;
    miss_flag_d = 1'b0;
    game_over_d = game_over;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d     = DRAW;
          score_d     = '0;
          misses_d    = '0;
          game_over_d = 1'b0;
          timer_d     = '0;
          ready_d     = 1'b1;
        end
      end

      DRAW: begin
        ready_d = 1'b1;
        // Invalid codes are still consumed; only a valid box leaves DRAW.
        if (rnd.rnd_valid && ready_q && map_valid) begin
          state_d = SHOW;
          mole_d  = map_box;
          timer_d = '0;
          ready_d = 1'b0;
        end
      end

      SHOW: begin
        if (|(hit & mole)) begin
          score_d    = sat_inc(score);
          hit_flag_d = 1'b1;
          mole_d     = BOX_NONE;
          timer_d    = '0;
          state_d    = GAP;
        end else if (timer_q == show_last) begin
          misses_d    = misses + 4'd1;
          miss_flag_d = 1'b1;
          mole_d      = BOX_NONE;
          timer_d     = '0;
          if (misses_d == 4'(MAX_MISSES)) begin
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            state_d = GAP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = DRAW;
          timer_d = '0;
          ready_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      mole      <= BOX_NONE;
      score     <= '0;
      misses    <= '0;
      ready_q   <= 1'b0;
      hit_flag  <= 1'b0;
      miss_flag <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mole      <= mole_d;
      score     <= score_d;
      misses    <= misses_d;
      ready_q   <= ready_d;
      hit_flag  <= hit_flag_d;
      miss_flag <= miss_flag_d;
      game_over <= game_over_d;
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomised bench for mole_round_ctrl against an event-level round model, plus directed scenarios.
module tb_mole_round_ctrl;

  localparam int SHOW    = 8;
  localparam int GAP     = 4;
  localparam int MAXMISS = 3;
  localparam int SW      = 8;
  localparam int SMAX    = 255;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [3:0]    hit;
  logic [3:0]    mole;
  logic [SW-1:0] score;
  logic [3:0]    misses;
  logic          hit_flag, miss_flag, game_over;

  mole_round_ctrl_if rnd_bus ();

  mole_round_ctrl #(
    .SHOW_CYCLES (SHOW),
    .GAP_CYCLES  (GAP),
    .SCORE_W     (SW),
    .MAX_MISSES  (MAXMISS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .rnd       (rnd_bus.slave),
    .hit       (hit),
    .mole      (mole),
    .score     (score),
    .misses    (misses),
    .hit_flag  (hit_flag),
    .miss_flag (miss_flag),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Box index for each code, -1 for the invalid code 000.
  int box_of [8] = '{-1, 0, 0, 1, 0, 1, 2, 3};

  // Round model: what the player would see, tracked as countdowns.
  bit m_draw, m_show, m_over, m_hit_flag, m_miss_flag;
  int m_box, m_show_left, m_gap_left, m_score, m_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_draw = 0; m_show = 0; m_over = 0; m_hit_flag = 0; m_miss_flag = 0;
    m_box = 0; m_show_left = 0; m_gap_left = 0; m_score = 0; m_misses = 0;
  endfunction

  function automatic void model_step(bit s, bit v, logic [2:0] val, logic [3:0] h);
    m_hit_flag  = 0;
    m_miss_flag = 0;
    if (m_show) begin
      if (h[m_box]) begin
        m_score    = (m_score < SMAX) ? m_score + 1 : SMAX;
        m_hit_flag = 1;
        m_show     = 0;
        m_gap_left = GAP;
      end else begin
        m_show_left--;
        if (m_show_left == 0) begin
          m_misses++;
          m_miss_flag = 1;
          m_show      = 0;
          if (m_misses == MAXMISS) m_over = 1;
          else                     m_gap_left = GAP;
        end
      end
    end else if (m_draw) begin
      if (v && box_of[val] >= 0) begin
        m_draw      = 0;
        m_show      = 1;
        m_box       = box_of[val];
        m_show_left = SHOW;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) m_draw = 1;
    end else if (s) begin
      m_over   = 0;
      m_score  = 0;
      m_misses = 0;
      m_draw   = 1;
    end
  endfunction

  function automatic logic [3:0] exp_mole();
    return m_show ? 4'(1 << m_box) : 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mole",      mole,              exp_mole());
      chk("score",     score,             m_score);
      chk("misses",    misses,            m_misses);
      chk("rnd_ready", rnd_bus.rnd_ready, m_draw);
      chk("hit_flag",  hit_flag,          m_hit_flag);
      chk("miss_flag", miss_flag,         m_miss_flag);
      chk("game_over", game_over,         m_over);
    end
  end

  // One clock: inputs change just after the falling edge, results are seen at the next one.
  task automatic cycle(input bit rn, input bit s, input bit v, input logic [2:0] val,
                       input logic [3:0] h);
    #1;
    resetn = rn; start = s; rnd_bus.rnd_valid = v; rnd_bus.rnd_value = val; hit = h;
    @(posedge clk);
    if (!rn) model_reset();
    else     model_step(s, v, val, h);
    @(negedge clk);
  endtask

  task automatic run_until_draw(input int budget);
    int n = 0;
    while (!m_draw && n < budget) begin
      cycle(1, 0, 0, 3'b000, 4'b0000);
      n++;
    end
    checks++;
    if (!m_draw) begin
      errors++;
      $display("FAIL draw_timeout actual=%0d required<%0d cycles", n, budget);
    end
  endtask

  initial begin
    logic [2:0] code;
    logic [3:0] hv;
    bit         rn;

    resetn = 0; start = 0; hit = 0; rnd_bus.rnd_valid = 0; rnd_bus.rnd_value = 0;
    model_reset();
    @(negedge clk);

    // Reset state
    cycle(0, 0, 0, 3'b000, 4'b0000);
    cmp_en = 1'b1;
    cycle(0, 1, 1, 3'b111, 4'b1111);
    chk("rst_mole", mole, 4'b0000);
    chk("rst_score", score, 8'd0);
    chk("rst_ready", rnd_bus.rnd_ready, 1'b0);
    chk("rst_over", game_over, 1'b0);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    chk("idle_ready", rnd_bus.rnd_ready, 1'b0);

    // Start, draw code 110 -> box2, hit it immediately
    cycle(1, 1, 0, 3'b000, 4'b0000);
    chk("draw_ready", rnd_bus.rnd_ready, 1'b1);
    cycle(1, 0, 1, 3'b110, 4'b0000);
    chk("mole_box2", mole, 4'b0100);
    chk("show_ready", rnd_bus.rnd_ready, 1'b0);
    cycle(1, 0, 0, 3'b000, 4'b0100);
    chk("hit1_score", score, 8'd1);
    chk("hit1_flag", hit_flag, 1'b1);

    // Code 000 consumed without a mole, then 011 -> box1
    run_until_draw(40);
    cycle(1, 0, 1, 3'b000, 4'b0000);
    chk("zero_mole", mole, 4'b0000);
    chk("zero_ready", rnd_bus.rnd_ready, 1'b1);
    cycle(1, 0, 1, 3'b011, 4'b0000);
    chk("mole_box1", mole, 4'b0010);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    cycle(1, 0, 0, 3'b000, 4'b0010);
    chk("hit2_score", score, 8'd2);

    // Box0, hit on the 3rd SHOW cycle, then a 4-cycle gap
    run_until_draw(40);
    cycle(1, 0, 1, 3'b001, 4'b0000);
    chk("mole_box0", mole, 4'b0001);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    cycle(1, 1, 0, 3'b000, 4'b0000);
    cycle(1, 0, 0, 3'b000, 4'b0001);
    chk("hit3_score", score, 8'd3);
    chk("hit3_flag", hit_flag, 1'b1);
    chk("hit3_mole", mole, 4'b0000);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    chk("hit3_flag_drop", hit_flag, 1'b0);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    chk("gap4_ready", rnd_bus.rnd_ready, 1'b0);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    chk("gap_done_ready", rnd_bus.rnd_ready, 1'b1);

    // Box3 with only wrong presses: miss after 8 SHOW cycles
    cycle(1, 0, 1, 3'b111, 4'b0000);
    chk("mole_box3", mole, 4'b1000);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 3'b000, 4'b0001);
    chk("pre_timeout_mole", mole, 4'b1000);
    cycle(1, 0, 0, 3'b000, 4'b0001);
    chk("miss1", misses, 4'd1);
    chk("miss1_flag", miss_flag, 1'b1);
    chk("miss1_score", score, 8'd3);

    // Two more timeouts end the round
    run_until_draw(40);
    cycle(1, 0, 1, 3'b101, 4'b0000);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 3'b000, 4'b0000);
    chk("miss2", misses, 4'd2);
    run_until_draw(40);
    cycle(1, 0, 1, 3'b010, 4'b0000);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 3'b000, 4'b0000);
    chk("miss3", misses, 4'd3);
    chk("over_set", game_over, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, 3'b111, 4'b1111);
      chk("over_ready", rnd_bus.rnd_ready, 1'b0);
    end
    cycle(1, 1, 0, 3'b000, 4'b0000);
    chk("restart_score", score, 8'd0);
    chk("restart_misses", misses, 4'd0);
    chk("restart_over", game_over, 1'b0);
    chk("restart_ready", rnd_bus.rnd_ready, 1'b1);

    // Correct hit on the timeout cycle counts as a hit
    cycle(1, 0, 1, 3'b101, 4'b0000);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 3'b000, 4'b0000);
    cycle(1, 0, 0, 3'b000, 4'b0010);
    chk("edge_hit_score", score, 8'd1);
    chk("edge_hit_misses", misses, 4'd0);
    chk("edge_miss_flag", miss_flag, 1'b0);

    // Asynchronous reset in the middle of SHOW
    run_until_draw(40);
    cycle(1, 0, 1, 3'b100, 4'b0000);
    cycle(1, 0, 0, 3'b000, 4'b0000);
    #2 resetn = 0;
    #1;
    chk("async_mole", mole, 4'b0000);
    chk("async_score", score, 8'd0);
    chk("async_flags", {hit_flag, miss_flag, game_over, rnd_bus.rnd_ready}, 4'b0000);
    model_reset();
    cycle(0, 0, 0, 3'b000, 4'b0000);
    cycle(1, 0, 0, 3'b000, 4'b0000);

    // Score saturation
    cycle(1, 1, 0, 3'b000, 4'b0000);
    for (int i = 0; i < 260; i++) begin
      run_until_draw(40);
      code = 3'($urandom_range(1, 7));
      cycle(1, 0, 1, code, 4'b0000);
      hv = 4'(1 << m_box);
      cycle(1, 0, 0, 3'b000, hv);
    end
    chk("score_sat", score, 8'd255);

    // Randomised play
    for (int i = 0; i < 3000; i++) begin
      rn   = ($urandom_range(0, 999) >= 3);
      code = 3'($urandom_range(0, 7));
      if (m_show && $urandom_range(0, 99) < 10) hv = 4'(1 << m_box) | 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 99) < 10)      hv = 4'($urandom_range(0, 15));
      else                                      hv = 4'b0000;
      cycle(rn, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 60, code, hv);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
